// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and constants for the I2S transmitter.
//   SAMPLE_W        - width of one channel sample
//   FRAME_SLOTS     - BCLK slots per stereo frame
//   stereo_sample_t - {left, right} pair, left in the upper half
package i2s_pkg;
  localparam int SAMPLE_W    = 16;
  localparam int FRAME_SLOTS = 32;
  localparam int SLOT_W      = $clog2(FRAME_SLOTS);

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } stereo_sample_t;
endpackage

// File: rtl/i2s_tx_if.sv
// i2s_tx_if: sample handshake between the filter chain and the transmitter.
//   left_in / right_in - two's complement samples
//   sample_valid       - pair on left_in/right_in is valid
//   sample_ready       - transmitter holding register is empty
// master = upstream producer, slave = i2s_tx.
interface i2s_tx_if;
  import i2s_pkg::*;

  logic [SAMPLE_W-1:0] left_in;
  logic [SAMPLE_W-1:0] right_in;
  logic                sample_valid;
  logic                sample_ready;

  modport master (output left_in, output right_in, output sample_valid,
                  input  sample_ready);
  modport slave  (input  left_in, input  right_in, input  sample_valid,
                  output sample_ready);
endinterface

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides clk down to the I2S bit clock.
//   clk, reset_n - system clock, async active-low reset
//   bclk_o       - bit clock, toggles every BCLK_DIV clk cycles
//   fall_en_o    - high in the clk cycle whose edge takes bclk 1->0
//   rise_en_o    - high in the clk cycle whose edge takes bclk 0->1
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic bclk_o,
  output logic fall_en_o,
  output logic rise_en_o
);
  localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(BCLK_DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic          term;

  assign term = (div_cnt_q == TERM);

  always_comb begin
    div_cnt_d = term ? '0 : div_cnt_q + 1'b1;
    bclk_d    = term ? ~bclk_q : bclk_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign bclk_o    = bclk_q;
  assign fall_en_o = term &  bclk_q;
  assign rise_en_o = term & ~bclk_q;
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: stereo Philips-I2S transmitter with a one-entry holding register.
//   clk, reset_n - system clock, async active-low reset
//   smp          - sample handshake (i2s_tx_if.slave)
//   mute         - only with I2S_TX_MUTE_EN: zero the word loaded at a frame start
//   bclk, lrclk  - bit clock and word select (0 = left)
//   sdata        - serial data, updated on bclk falling edges
//   underrun     - one-clk pulse when a frame starts with no pair available
// Optional feature macro: I2S_TX_MUTE_EN.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  i2s_tx_if.slave  smp,
`ifdef I2S_TX_MUTE_EN
  input  logic     mute,
`endif
  output logic     bclk,
  output logic     lrclk,
  output logic     sdata,
  output logic     underrun
);
  logic fall_en, rise_en;

  i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
    .clk       (clk),
    .reset_n   (reset_n),
    .bclk_o    (bclk),
    .fall_en_o (fall_en),
    .rise_en_o (rise_en)
  );

  logic [SLOT_W-1:0]     slot_cnt_q, slot_cnt_d;
  logic [2*SAMPLE_W-1:0] shreg_q, shreg_d;
  stereo_sample_t        hold_q, hold_d;
  logic                  empty_q, empty_d;
  logic                  sdata_q, sdata_d;
  logic                  lrclk_q, lrclk_d;
  logic                  underrun_q, underrun_d;

  stereo_sample_t in_pair, word;
  logic           load;

  assign in_pair = '{l: smp.left_in, r: smp.right_in};
  // Slot 31 -> 0 transition: the frame boundary where a new pair is loaded.
  assign load    = fall_en && (slot_cnt_q == SLOT_W'(FRAME_SLOTS - 1));

  always_comb begin
    slot_cnt_d = slot_cnt_q;
    shreg_d    = shreg_q;
    hold_d     = hold_q;
    empty_d    = empty_q;
    sdata_d    = sdata_q;
    lrclk_d    = lrclk_q;
    underrun_d = 1'b0;
    word       = '0;

    if (fall_en) begin
      slot_cnt_d = slot_cnt_q + 1'b1;
      sdata_d    = shreg_q[2*SAMPLE_W-1];
      lrclk_d    = (slot_cnt_d >= SLOT_W'(FRAME_SLOTS / 2));
      shreg_d    = shreg_q << 1;
    end

    if (load) begin
      if (!empty_q) begin
        word    = hold_q;
        empty_d = 1'b1;
      end else if (smp.sample_valid) begin
        // Bypass: the handshake completes straight into the shifter.
        word = in_pair;
      end else begin
        underrun_d = 1'b1;
      end
`ifdef I2S_TX_MUTE_EN
      if (mute) word = '0;
`endif
      shreg_d = word;
    end else if (smp.sample_valid && empty_q) begin
      hold_d  = in_pair;
      empty_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt_q <= SLOT_W'(FRAME_SLOTS - 1);
      shreg_q    <= '0;
      hold_q     <= '0;
      empty_q    <= 1'b1;
      sdata_q    <= 1'b0;
      lrclk_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      shreg_q    <= shreg_d;
      hold_q     <= hold_d;
      empty_q    <= empty_d;
      sdata_q    <= sdata_d;
      lrclk_q    <= lrclk_d;
      underrun_q <= underrun_d;
    end
  end

  // A bclk edge is either a rise or a fall, never both.
  a_edge_excl: assert property (@(posedge clk) disable iff (!reset_n)
                                !(rise_en && fall_en));

  assign smp.sample_ready = empty_q;
  assign sdata            = sdata_q;
  assign lrclk            = lrclk_q;
  assign underrun         = underrun_q;
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed self-checking bench for i2s_tx at BCLK_DIV=4.
// Edges are counted from reset release; load cycles fall at 8+256k and the
// receiver samples each slot s at edge 12+256k+8s (bclk rise).
module tb_i2s_tx;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic bclk, lrclk, sdata, underrun;
`ifdef I2S_TX_MUTE_EN
  logic mute = 1'b0;
`endif

  i2s_tx_if bus ();

  i2s_tx #(.BCLK_DIV(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .smp      (bus),
`ifdef I2S_TX_MUTE_EN
    .mute     (mute),
`endif
    .bclk     (bclk),
    .lrclk    (lrclk),
    .sdata    (sdata),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int          ncmp = 0, nfail = 0;
  int          ecnt = 0, ur_cnt = 0, last_ur = -1, prev_ur = -1, ur_wide = 0;
  int          acc_cnt = 0;
  logic        ur_lvl = 1'b0, auto_inc = 1'b0;
  logic [15:0] n = '0;
  logic [31:0] w, lr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clk edge; inputs only change #1 after an edge so valid&ready seen
  // here is what the DUT samples.
  task automatic step();
    logic acc;
    acc = bus.sample_valid && bus.sample_ready && reset_n;
    @(posedge clk); #1;
    ecnt++;
    if (acc) begin
      acc_cnt++;
      if (auto_inc) begin
        n = n + 16'd1;
        bus.left_in  = 16'h1000 + n;
        bus.right_in = 16'h2000 + n;
      end
    end
    if (underrun === 1'b1) begin
      ur_cnt++;
      prev_ur = last_ur;
      last_ur = ecnt;
      if (ur_lvl) ur_wide++;
    end
    ur_lvl = (underrun === 1'b1);
  endtask

  task automatic step_to(input int t);
    while (ecnt < t) step();
  endtask

  // Called at a slot-0 rise; samples slots 1..31 and the next slot 0.
  task automatic rx_frame(output logic [31:0] wo, output logic [31:0] lro);
    wo = '0; lro = '0;
    for (int i = 0; i < 32; i++) begin
      repeat (8) step();
      wo  = {wo[30:0], sdata};
      lro = {lro[30:0], lrclk};
    end
  endtask

  initial begin
    bus.left_in = '0; bus.right_in = '0; bus.sample_valid = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_bclk", bclk, 0);
    check("rst_lrclk", lrclk, 0);
    check("rst_sdata", sdata, 0);
    check("rst_underrun", underrun, 0);
    check("rst_ready", bus.sample_ready, 1);

    // First frame: pair accepted into holding register at edge 1
    bus.left_in = 16'hA5F0; bus.right_in = 16'h0F0F; bus.sample_valid = 1'b1;
    reset_n = 1'b1; ecnt = 0;
    step();
    check("ready_after_accept", bus.sample_ready, 0);
    bus.sample_valid = 1'b0;
    step_to(12);
    check("slot0_bclk", bclk, 1);
    check("slot0_sdata", sdata, 0);
    check("slot0_lrclk", lrclk, 0);
    rx_frame(w, lr);
    check("frame1_word", w, 32'hA5F0_0F0F);
    check("frame1_lrclk", lr, 32'h0001_FFFE);
    check("frame2_underrun_cnt", ur_cnt, 1);
    check("frame2_underrun_edge", last_ur, 264);

    // Three frames with no samples
    for (int f = 0; f < 3; f++) begin
      rx_frame(w, lr);
      check("idle_word", w, 0);
    end
    check("idle_underrun_cnt", ur_cnt, 4);
    check("idle_underrun_edge", last_ur, 1032);
    check("idle_underrun_period", last_ur - prev_ur, 256);
    check("underrun_width", ur_wide, 0);

    // Streaming incrementing pairs
    n = '0; acc_cnt = 0; auto_inc = 1'b1;
    bus.left_in = 16'h1000; bus.right_in = 16'h2000; bus.sample_valid = 1'b1;
    rx_frame(w, lr);
    check("stream_first_zero", w, 0);
    rx_frame(w, lr);
    check("stream_pair0", w, 32'h1000_2000);
    rx_frame(w, lr);
    check("stream_pair1", w, 32'h1001_2001);
    check("stream_accepts", acc_cnt, 4);
    auto_inc = 1'b0; bus.sample_valid = 1'b0;
    rx_frame(w, lr);
    check("stream_pair2", w, 32'h1002_2002);
    check("stream_underrun_cnt", ur_cnt, 4);

    // Bypass: single-cycle valid exactly at load edge 2312, holding empty
    step_to(2311);
    bus.left_in = 16'h8001; bus.right_in = 16'h1234; bus.sample_valid = 1'b1;
    step();
    bus.sample_valid = 1'b0;
    check("bypass_ready", bus.sample_ready, 1);
    check("bypass_underrun", underrun, 0);
    step_to(2316);
    rx_frame(w, lr);
    check("bypass_word", w, 32'h8001_1234);
    check("bypass_underrun_cnt", ur_cnt, 5);

    // Reset mid-frame at slot 10 (fall at 2648)
    step_to(2650);
    reset_n = 1'b0; #1;
    check("midrst_bclk", bclk, 0);
    check("midrst_lrclk", lrclk, 0);
    check("midrst_sdata", sdata, 0);
    check("midrst_underrun", underrun, 0);
    check("midrst_ready", bus.sample_ready, 1);
    repeat (3) step();
    bus.left_in = 16'hCAFE; bus.right_in = 16'hBEEF; bus.sample_valid = 1'b1;
    reset_n = 1'b1; ecnt = 0;
    step();
    bus.sample_valid = 1'b0;
    step_to(4);
    check("midrst_first_rise", bclk, 1);
    step_to(7);
    check("midrst_pre_load_bclk", bclk, 1);
    step_to(8);
    check("midrst_load_fall", bclk, 0);
    step_to(12);
    check("midrst_slot0_sdata", sdata, 0);
    rx_frame(w, lr);
    check("midrst_word", w, 32'hCAFE_BEEF);

`ifdef I2S_TX_MUTE_EN
    // Mute at load edge 520 with a pending pair
    bus.left_in = 16'h7FFF; bus.right_in = 16'h7FFF; bus.sample_valid = 1'b1;
    step();
    bus.sample_valid = 1'b0;
    check("mute_pending", bus.sample_ready, 0);
    ur_cnt = 0;
    step_to(519);
    mute = 1'b1;
    step();
    mute = 1'b0;
    check("mute_consumed", bus.sample_ready, 1);
    check("mute_underrun", underrun, 0);
    step_to(524);
    rx_frame(w, lr);
    check("mute_word", w, 0);
    check("mute_underrun_cnt", ur_cnt, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
